// File: rtl/flash_erase_ctrl_if.sv
// Bus bundle for the SPI NOR erase sequencer: request handshake plus flash pins.
// Latency: none (wires only).
// Backpressure: none; start is only honoured while the sequencer is idle.
//
// Signals:
//   start, mode, addr : erase request (mode 0 = bulk, 1 = sector)
//   busy, done        : sequence status
//   sck, cs_n, mosi   : SPI mode 0 outputs to the flash
//   miso              : SPI data from the flash (status polling only)
// Modports: master = the sequencer, slave = requester/flash side.
interface flash_erase_ctrl_if #(
  parameter int ADDR_W = 24
);
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              done;
  logic              sck;
  logic              cs_n;
  logic              mosi;
  logic              miso;

  modport master (
    input  start, mode, addr, miso,
    output busy, done, sck, cs_n, mosi
  );

  modport slave (
    output start, mode, addr, miso,
    input  busy, done, sck, cs_n, mosi
  );
endinterface

// File: rtl/flash_erase_ctrl.sv
// SPI NOR erase sequencer: WREN (0x06) then bulk (0xC7) or sector (0xD8+addr) erase.
// Latency: busy the cycle after start; done after all frames and cs_n gaps complete.
// Backpressure: start is sampled only in IDLE; requests while busy or in DONE are dropped.
//
// Ports: sys_clk, sys_rst_n (async active-low), bus (flash_erase_ctrl_if.master):
//   start/mode/addr request, busy/done status, sck/cs_n/mosi/miso SPI mode 0.
// Optional macro STATUS_POLL_EN: after the erase frame, poll the status register
//   (0x05) until WIP=0, then a final cs_n gap before done.
module flash_erase_ctrl #(
  parameter int CLK_DIV = 2,   // sys_clk cycles per sck half-period, >= 2
  parameter int CS_GAP  = 32,  // sys_clk cycles of cs_n high between frames, >= 1
  parameter int ADDR_W  = 24   // sector address width, multiple of 8, 8..32
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  flash_erase_ctrl_if.master bus
);

  localparam int SH_W  = 8 + ADDR_W;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CS_GAP - 1);
  localparam logic [5:0]       OP_LAST   = 6'd7;
  localparam logic [5:0]       SECT_LAST = 6'(SH_W - 1);
`ifdef STATUS_POLL_EN
  localparam logic [5:0]       POLL_LAST = 6'd15;  // last bit of a status byte
  localparam logic [5:0]       POLL_WRAP = 6'd8;   // first bit of the next status byte
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WREN  = 3'd1,
    S_GAP1  = 3'd2,
    S_ERASE = 3'd3,
    S_GAP2  = 3'd4,
`ifdef STATUS_POLL_EN
    S_POLL  = 3'd5,
    S_GAP3  = 3'd6,
`endif
    S_DONE  = 3'd7
  } state_t;

  state_t            state;
  logic              mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [SH_W-1:0]   shreg;    // current bit is always shreg[SH_W-1]
  logic [5:0]        bit_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              tail;     // post-last-fall hold before cs_n rises
  logic              sck_q;
  logic              cs_n_q;
  logic              mosi_q;
  logic              busy_q;
  logic              done_q;
`ifdef STATUS_POLL_EN
  logic [7:0]        stat_q;   // status byte shifted in on sck rising edges
`endif

  logic   in_frame;
  logic   in_gap;
  logic   last_bit;
  state_t next_gap;

  always_comb begin
    in_frame = (state == S_WREN) || (state == S_ERASE);
    in_gap   = (state == S_GAP1) || (state == S_GAP2);
    last_bit = 1'b0;
    next_gap = S_GAP1;
`ifdef STATUS_POLL_EN
    if (state == S_POLL) in_frame = 1'b1;
    if (state == S_GAP3) in_gap   = 1'b1;
`endif
    case (state)
      S_WREN: begin
        last_bit = (bit_cnt == OP_LAST);
        next_gap = S_GAP1;
      end
      S_ERASE: begin
        last_bit = (bit_cnt == (mode_q ? SECT_LAST : OP_LAST));
        next_gap = S_GAP2;
      end
`ifdef STATUS_POLL_EN
      // Only a completed status byte with WIP clear may end the poll frame.
      S_POLL: begin
        last_bit = (bit_cnt == POLL_LAST) && !stat_q[0];
        next_gap = S_GAP3;
      end
`endif
      default: begin
        last_bit = 1'b0;
        next_gap = S_GAP1;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= S_IDLE;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      gap_cnt <= '0;
      tail    <= 1'b0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef STATUS_POLL_EN
      stat_q  <= '0;
`endif
    end else if (in_frame) begin
      if (div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + 1'b1;
      end else if (!tail) begin
        div_cnt <= '0;
        if (!sck_q) begin
          sck_q <= 1'b1;
`ifdef STATUS_POLL_EN
          if (state == S_POLL) stat_q <= {stat_q[6:0], bus.miso};
`endif
        end else begin
          sck_q <= 1'b0;
          if (last_bit) begin
            tail <= 1'b1;
          end else begin
            // Next bit goes out on the falling edge; zeros shift in, so
            // mosi stays low once the opcode/address has been sent.
            shreg  <= shreg << 1;
            mosi_q <= shreg[SH_W-2];
`ifdef STATUS_POLL_EN
            if (state == S_POLL && bit_cnt == POLL_LAST) bit_cnt <= POLL_WRAP;
            else                                         bit_cnt <= bit_cnt + 6'd1;
`else
            bit_cnt <= bit_cnt + 6'd1;
`endif
          end
        end
      end else begin
        div_cnt <= '0;
        tail    <= 1'b0;
        bit_cnt <= '0;
        cs_n_q  <= 1'b1;
        mosi_q  <= 1'b0;
        state   <= next_gap;
      end
    end else if (in_gap) begin
      if (gap_cnt != GAP_LAST) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
        if (state == S_GAP1) begin
          state  <= S_ERASE;
          cs_n_q <= 1'b0;
          mosi_q <= 1'b1;  // bit 7 of both 0xC7 and 0xD8
          shreg  <= mode_q ? {8'hD8, addr_q} : {8'hC7, {ADDR_W{1'b0}}};
`ifdef STATUS_POLL_EN
        end else if (state == S_GAP2) begin
          state  <= S_POLL;
          cs_n_q <= 1'b0;
          mosi_q <= 1'b0;  // bit 7 of 0x05
          shreg  <= {8'h05, {ADDR_W{1'b0}}};
`endif
        end else begin
          state  <= S_DONE;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            mode_q <= bus.mode;
            addr_q <= bus.addr;
            busy_q <= 1'b1;
            state  <= S_WREN;
            cs_n_q <= 1'b0;
            mosi_q <= 1'b0;  // bit 7 of 0x06
            shreg  <= {8'h06, {ADDR_W{1'b0}}};
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.sck  = sck_q;
  assign bus.cs_n = cs_n_q;
  assign bus.mosi = mosi_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_flash_erase_ctrl.sv
// Directed bench for flash_erase_ctrl: one instance at CLK_DIV=2, one at CLK_DIV=5.
// A negedge monitor decodes SPI frames, gaps and sck phase lengths per instance.
module tb_flash_erase_ctrl;
  localparam int AW = 24;

`ifdef STATUS_POLL_EN
  localparam int NFR    = 3;
  localparam int EXP_B2 = 295;
  localparam int EXP_S2 = 391;
  localparam int EXP_B5 = 432;
`else
  localparam int NFR    = 2;
  localparam int EXP_B2 = 133;
  localparam int EXP_S2 = 229;
  localparam int EXP_B5 = 235;
`endif

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  logic clr_mon   = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   n;

  always #5 sys_clk = ~sys_clk;

  flash_erase_ctrl_if #(.ADDR_W(AW)) bus  ();
  flash_erase_ctrl_if #(.ADDR_W(AW)) bus5 ();

  flash_erase_ctrl #(.CLK_DIV(2), .CS_GAP(32), .ADDR_W(AW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));
  flash_erase_ctrl #(.CLK_DIV(5), .CS_GAP(32), .ADDR_W(AW)) dut5 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus5));

  logic [1:0] v_sck, v_cs, v_mosi, v_busy, v_done;
  assign v_sck  = {bus5.sck,  bus.sck};
  assign v_cs   = {bus5.cs_n, bus.cs_n};
  assign v_mosi = {bus5.mosi, bus.mosi};
  assign v_busy = {bus5.busy, bus.busy};
  assign v_done = {bus5.done, bus.done};

  int          f_cnt [2];
  logic [63:0] f_dat [2][8];
  int          f_bits[2][8];
  int          f_low [2][8];
  int          f_gap [2][8];
  int          cur_bits[2];
  logic [63:0] cur_dat [2];
  int          low_cnt[2], hi_cs[2];
  int          done_cnt[2], busy_viol[2], mosi_viol[2];
  int          hi_run[2], lo_run[2], hi_min[2], hi_max[2], lo_min[2], lo_max[2];
  logic        p_sck[2], p_cs[2], p_mosi[2], p_busy[2];

  // Flash model: status bytes 0x03, 0x01, 0x00 follow the 8 opcode bits.
  function automatic logic poll_bit(input int nb);
    logic [23:0] st;
    st = 24'h030100;
    if (nb < 8 || nb >= 32) return 1'b0;
    return st[23 - (nb - 8)];
  endfunction

  assign bus.miso  = poll_bit(cur_bits[0]);
  assign bus5.miso = 1'b0;

  always @(negedge sys_clk) begin
    for (int k = 0; k < 2; k++) begin
      if (clr_mon) begin
        f_cnt[k] = 0; done_cnt[k] = 0; busy_viol[k] = 0; mosi_viol[k] = 0;
        hi_min[k] = 1000; hi_max[k] = 0; lo_min[k] = 1000; lo_max[k] = 0;
      end
      if (!sys_rst_n) begin
        p_sck[k] = 1'b0; p_cs[k] = 1'b1; p_mosi[k] = 1'b0; p_busy[k] = 1'b0;
        cur_bits[k] = 0; hi_cs[k] = 0;
      end else begin
        if (p_cs[k] && !v_cs[k]) begin
          if (f_cnt[k] < 8) f_gap[k][f_cnt[k]] = hi_cs[k];
          cur_bits[k] = 0; cur_dat[k] = '0; low_cnt[k] = 0; lo_run[k] = 0; hi_run[k] = 0;
        end
        if (!p_cs[k] && v_cs[k]) begin
          if (f_cnt[k] < 8) begin
            f_dat[k][f_cnt[k]]  = cur_dat[k];
            f_bits[k][f_cnt[k]] = cur_bits[k];
            f_low[k][f_cnt[k]]  = low_cnt[k];
          end
          f_cnt[k]++;
          hi_cs[k] = 0;
        end
        if (!v_cs[k]) begin
          if (!p_sck[k] && v_sck[k]) begin
            cur_dat[k] = {cur_dat[k][62:0], v_mosi[k]};
            cur_bits[k]++;
            if (lo_run[k] < lo_min[k]) lo_min[k] = lo_run[k];
            if (lo_run[k] > lo_max[k]) lo_max[k] = lo_run[k];
            lo_run[k] = 0;
          end
          if (p_sck[k] && !v_sck[k]) begin
            if (hi_run[k] < hi_min[k]) hi_min[k] = hi_run[k];
            if (hi_run[k] > hi_max[k]) hi_max[k] = hi_run[k];
            hi_run[k] = 0;
          end
          if (v_sck[k]) hi_run[k]++; else lo_run[k]++;
          low_cnt[k]++;
          if (v_sck[k] && p_sck[k] && (v_mosi[k] != p_mosi[k])) mosi_viol[k]++;
        end else begin
          hi_cs[k]++;
        end
        if (v_done[k]) begin
          done_cnt[k]++;
          if (v_busy[k] || !p_busy[k]) busy_viol[k]++;
        end else if (p_busy[k] && !v_busy[k]) begin
          busy_viol[k]++;
        end
        p_sck[k] = v_sck[k]; p_cs[k] = v_cs[k]; p_mosi[k] = v_mosi[k]; p_busy[k] = v_busy[k];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    clr_mon = 1'b1;
    @(negedge sys_clk);
    #1 clr_mon = 1'b0;
  endtask

  // Pulse start on instance k, change addr right after acceptance, then wait
  // (bounded) for done. n = negedges from the start drive to the done sample.
  task automatic run_seq(input int k, input logic m, input logic [AW-1:0] a,
                         input logic [AW-1:0] a2, output int cnt);
    if (k == 0) begin bus.mode = m;  bus.addr = a;  bus.start = 1'b1;  end
    else        begin bus5.mode = m; bus5.addr = a; bus5.start = 1'b1; end
    @(negedge sys_clk);
    cnt = 1;
    if (k == 0) begin bus.start = 1'b0;  bus.addr = a2;  end
    else        begin bus5.start = 1'b0; bus5.addr = a2; end
    check("busy_after_start", (k == 0) ? bus.busy : bus5.busy, 1'b1);
    while (((k == 0) ? bus.done : bus5.done) !== 1'b1 && cnt < 3000) begin
      @(negedge sys_clk);
      cnt++;
    end
  endtask

  initial begin
    bus.start = 0;  bus.mode = 0;  bus.addr = '0;
    bus5.start = 0; bus5.mode = 0; bus5.addr = '0;
    #2 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_sck",  bus.sck,  1'b0);
    check("rst_cs_n", bus.cs_n, 1'b1);
    check("rst_mosi", bus.mosi, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    sys_rst_n = 1'b1;
    clear_mon();

    // Bulk erase at CLK_DIV=2.
    run_seq(0, 1'b0, '0, '0, n);
    repeat (5) @(negedge sys_clk);
    check("bulk_done_cycle", n, EXP_B2);
    check("bulk_frames",     f_cnt[0], NFR);
    check("bulk_f0_dat",     f_dat[0][0], 64'h06);
    check("bulk_f0_bits",    f_bits[0][0], 8);
    check("bulk_f0_low",     f_low[0][0], 34);
    check("bulk_f1_dat",     f_dat[0][1], 64'hC7);
    check("bulk_f1_bits",    f_bits[0][1], 8);
    check("bulk_f1_low",     f_low[0][1], 34);
    check("bulk_gap1",       f_gap[0][1], 32);
    check("bulk_done_cnt",   done_cnt[0], 1);
    check("bulk_busy_viol",  busy_viol[0], 0);
    check("bulk_mosi_viol",  mosi_viol[0], 0);
`ifdef STATUS_POLL_EN
    check("poll_dat",  f_dat[0][2], 64'h05000000);
    check("poll_bits", f_bits[0][2], 32);
    check("poll_low",  f_low[0][2], 130);
    check("poll_gap2", f_gap[0][2], 32);
`endif

    // Sector erase, addr changed after acceptance.
    clear_mon();
    run_seq(0, 1'b1, 24'h123456, 24'hFFFFFF, n);
    repeat (5) @(negedge sys_clk);
    check("sect_done_cycle", n, EXP_S2);
    check("sect_f0_dat",     f_dat[0][0], 64'h06);
    check("sect_f1_dat",     f_dat[0][1], 64'hD8123456);
    check("sect_f1_bits",    f_bits[0][1], 32);
    check("sect_f1_low",     f_low[0][1], 130);
    check("sect_done_cnt",   done_cnt[0], 1);
    check("sect_mosi_viol",  mosi_viol[0], 0);

    // Start pulses while busy and in the DONE cycle are ignored.
    clear_mon();
    bus.mode = 1'b0; bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    repeat (40) @(negedge sys_clk);
    bus.mode = 1'b1; bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    repeat (300) @(negedge sys_clk);
    check("ign_done_cnt", done_cnt[0], 1);
    check("ign_frames",   f_cnt[0], NFR);
    check("ign_f1_dat",   f_dat[0][1], 64'hC7);
    check("ign_busy",     bus.busy, 1'b0);

    // Reset in the middle of a sector ERASE frame (sck high, mosi=1).
    clear_mon();
    bus.mode = 1'b1; bus.addr = 24'hABCDEF; bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    repeat (80) @(negedge sys_clk);
    check("pre_rst_cs_n", bus.cs_n, 1'b0);
    check("pre_rst_sck",  bus.sck,  1'b1);
    check("pre_rst_mosi", bus.mosi, 1'b1);
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_sck",  bus.sck,  1'b0);
    check("mid_rst_cs_n", bus.cs_n, 1'b1);
    check("mid_rst_mosi", bus.mosi, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    clear_mon();
    repeat (200) @(negedge sys_clk);
    check("post_rst_no_done", done_cnt[0], 0);
    check("post_rst_frames",  f_cnt[0], 0);
    run_seq(0, 1'b0, '0, '0, n);
    repeat (5) @(negedge sys_clk);
    check("rerun_done_cycle", n, EXP_B2);
    check("rerun_f1_dat",     f_dat[0][1], 64'hC7);
    check("rerun_done_cnt",   done_cnt[0], 1);

    // Bulk erase at CLK_DIV=5.
    clear_mon();
    run_seq(1, 1'b0, '0, '0, n);
    repeat (5) @(negedge sys_clk);
    check("div5_done_cycle", n, EXP_B5);
    check("div5_f0_low",     f_low[1][0], 85);
    check("div5_f0_dat",     f_dat[1][0], 64'h06);
    check("div5_f1_dat",     f_dat[1][1], 64'hC7);
    check("div5_hi_min",     hi_min[1], 5);
    check("div5_hi_max",     hi_max[1], 5);
    check("div5_lo_min",     lo_min[1], 5);
    check("div5_lo_max",     lo_max[1], 5);
    check("div5_mosi_viol",  mosi_viol[1], 0);
    check("div5_done_cnt",   done_cnt[1], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
